// File: rtl/stopwatch_counter_if.sv
// Control/display bundle for the stopwatch counter datapath.
// master: control FSM side; slave: counter datapath side.
interface stopwatch_counter_if;
    logic       init_regs;
    logic       count_enabled;
    logic [3:0] tenths;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] minutes;
    logic       tick;
    logic       overflow;

    modport master (
        output init_regs,
        output count_enabled,
        input  tenths,
        input  sec_ones,
        input  sec_tens,
        input  minutes,
        input  tick,
        input  overflow
    );

    modport slave (
        input  init_regs,
        input  count_enabled,
        output tenths,
        output sec_ones,
        output sec_tens,
        output minutes,
        output tick,
        output overflow
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch time base and M:SS.t BCD digit cascade.
// Define COUNTER_SATURATE_EN to hold at 9:59.9 instead of wrapping.
module stopwatch_counter #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 10
) (
    input logic              clk,
    input logic              reset,
    stopwatch_counter_if.slave bus
);
    localparam int PRESCALE = CLK_FREQ / TICK_HZ;
    localparam int PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_q;
    logic [3:0]    t_q, so_q, st_q, m_q;
    logic [3:0]    t_n, so_n, st_n, m_n;
    logic          tick_q, ovf_q;
    logic          t9, so9, st5, m9;
    logic          terminal;
    logic          sat;

    assign t9       = (t_q  == 4'd9);
    assign so9      = (so_q == 4'd9);
    assign st5      = (st_q == 4'd5);
    assign m9       = (m_q  == 4'd9);
    assign terminal = t9 & so9 & st5 & m9;

`ifdef COUNTER_SATURATE_EN
    assign sat = ovf_q;
`else
    assign sat = 1'b0;
`endif

    always_comb begin
        t_n  = t9 ? 4'd0 : t_q + 4'd1;
        so_n = so_q;
        st_n = st_q;
        m_n  = m_q;
        if (t9) begin
            so_n = so9 ? 4'd0 : so_q + 4'd1;
            if (so9) begin
                st_n = st5 ? 4'd0 : st_q + 4'd1;
                if (st5) begin
                    m_n = m9 ? 4'd0 : m_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q   <= '0;
            t_q    <= 4'd0;
            so_q   <= 4'd0;
            st_q   <= 4'd0;
            m_q    <= 4'd0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.init_regs) begin
            ps_q   <= '0;
            t_q    <= 4'd0;
            so_q   <= 4'd0;
            st_q   <= 4'd0;
            m_q    <= 4'd0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (bus.count_enabled && !sat) begin
                if (ps_q == PS_LAST) begin
                    ps_q <= '0;
                    if (terminal) begin
                        ovf_q <= 1'b1;
                    end
`ifdef COUNTER_SATURATE_EN
                    // at terminal count the digits freeze and tick is withheld
                    if (!terminal) begin
`else
                    begin
`endif
                        t_q    <= t_n;
                        so_q   <= so_n;
                        st_q   <= st_n;
                        m_q    <= m_n;
                        tick_q <= 1'b1;
                    end
                end else begin
                    ps_q <= ps_q + PW'(1);
                end
            end
        end
    end

    assign bus.tenths   = t_q;
    assign bus.sec_ones = so_q;
    assign bus.sec_tens = st_q;
    assign bus.minutes  = m_q;
    assign bus.tick     = tick_q;
    assign bus.overflow = ovf_q;
endmodule
